// File: rtl/onchip_mem_arbiter.sv
// Two-requester arbiter in front of a single-port on-chip RAM with fixed read latency of one cycle.
// Define ONCHIP_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 always wins a tie.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic              req0, req1;
  logic              gnt_valid, gnt_idx;
  logic              sel_read, sel_write;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [BE_W-1:0]   sel_be, be_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q;
  logic              last_grant, rd_pend, rd_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Handshake: a request is accepted in any cycle where it is asserted and its waitrequest is low.
  always_comb begin
    gnt_valid = reset_n & (req0 | req1);
    gnt_idx   = 1'b0;
    if (req0 && req1) begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
      gnt_idx = ~last_grant;
`else
      gnt_idx = 1'b0;
`endif
    end else begin
      gnt_idx = ~req0;
    end
  end

`ifndef ONCHIP_ARB_ROUND_ROBIN_EN
  // last_grant is still tracked but does not steer a fixed-priority build.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  assign sel_read  = gnt_idx ? m1_read       : m0_read;
  assign sel_write = gnt_idx ? m1_write      : m0_write;
  assign sel_addr  = gnt_idx ? m1_address    : m0_address;
  assign sel_be    = gnt_idx ? m1_byteenable : m0_byteenable;
  assign sel_wdata = gnt_idx ? m1_writedata  : m0_writedata;

  assign m0_waitrequest = ~reset_n | (req0 & ~(gnt_valid & (gnt_idx == 1'b0)));
  assign m1_waitrequest = ~reset_n | (req1 & ~(gnt_valid & (gnt_idx == 1'b1)));

  // Address/data hold their last granted values while idle to avoid needless RAM input toggling.
  assign mem_address    = gnt_valid ? sel_addr  : addr_q;
  assign mem_byteenable = gnt_valid ? sel_be    : be_q;
  assign mem_writedata  = gnt_valid ? sel_wdata : wdata_q;
  assign mem_chipselect = gnt_valid;
  assign mem_write      = gnt_valid & sel_write;
  assign mem_clken      = reset_n;

  // Gating with reset_n drops a return that would land in a reset cycle.
  assign m0_readdatavalid = reset_n & rd_pend & (rd_owner == 1'b0);
  assign m1_readdatavalid = reset_n & rd_pend & (rd_owner == 1'b1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else begin
      if (gnt_valid) begin
        last_grant <= gnt_idx;
        addr_q     <= sel_addr;
        be_q       <= sel_be;
        wdata_q    <= sel_wdata;
      end
      // A combined read+write executes as a write only, so it never returns data.
      rd_pend  <= gnt_valid & sel_read & ~sel_write;
      rd_owner <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural one-cycle-latency RAM behind it.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken;

  int checks = 0;
  int errors = 0;
  logic [31:0] ram [0:65535];
  logic        g [0:3];

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Synchronous RAM: registered q, byte-lane writes, old data on same-cycle read/write.
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  // Inputs change on the falling edge; checks land 1ns later, well before the next rising edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    g[0] = 0; g[1] = 1; g[2] = 0; g[3] = 1;
`else
    g[0] = 0; g[1] = 0; g[2] = 0; g[3] = 0;
`endif
    reset_n = 0;
    idle();
    drive0(1, 0, 16'h0000, 4'hF, 32'h0);
    drive1(0, 0, 16'h0000, 4'hF, 32'h0);
    next_cycle(); #1;
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_wait1", m1_waitrequest, 1);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_clken", mem_clken, 0);
    chk("rst_rdv0", m0_readdatavalid, 0);
    next_cycle(); idle();
    next_cycle(); reset_n = 1;
    #1 chk("clken_run", mem_clken, 1);

    // m0 write then read of the same address
    next_cycle(); drive0(0, 1, 16'h0010, 4'hF, 32'hDEADBEEF);
    #1 chk("w0_wait", m0_waitrequest, 0);
    chk("w0_cs", mem_chipselect, 1);
    chk("w0_memwr", mem_write, 1);
    chk("w0_addr", mem_address, 32'h0010);
    next_cycle(); drive0(1, 0, 16'h0010, 4'hF, 32'h0);
    #1 chk("r0_wait", m0_waitrequest, 0);
    chk("r0_memwr", mem_write, 0);
    chk("r0_rdv_early", m0_readdatavalid, 0);
    next_cycle(); idle();
    #1 chk("r0_rdv", m0_readdatavalid, 1);
    chk("r0_data", m0_readdata, 32'hDEADBEEF);
    chk("r0_rdv1", m1_readdatavalid, 0);
    chk("idle_cs", mem_chipselect, 0);
    chk("idle_addr_hold", mem_address, 32'h0010);
    next_cycle(); #1 chk("r0_rdv_once", m0_readdatavalid, 0);

    // m1 partial-byte write over a full word
    next_cycle(); drive1(0, 1, 16'h0020, 4'hF, 32'hFFFFFFFF);
    #1 chk("w1_wait", m1_waitrequest, 0);
    next_cycle(); drive1(0, 1, 16'h0020, 4'h3, 32'h11223344);
    #1 chk("w1_be", mem_byteenable, 32'h3);
    next_cycle(); drive1(1, 0, 16'h0020, 4'hF, 32'h0);
    #1 chk("r1_wait", m1_waitrequest, 0);
    next_cycle(); idle();
    #1 chk("r1_rdv", m1_readdatavalid, 1);
    chk("r1_rdv0", m0_readdatavalid, 0);
    chk("r1_data", m1_readdata, 32'hFFFF3344);

    // Both read continuously; last grant before this was m1
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      drive0(1, 0, 16'h0010, 4'hF, 32'h0);
      drive1(1, 0, 16'h0020, 4'hF, 32'h0);
      #1 chk($sformatf("tie%0d_wait0", i), m0_waitrequest, g[i]);
      chk($sformatf("tie%0d_wait1", i), m1_waitrequest, !g[i]);
      chk($sformatf("tie%0d_addr", i), mem_address, g[i] ? 32'h0020 : 32'h0010);
      if (i > 0) begin
        chk($sformatf("tie%0d_rdv0", i), m0_readdatavalid, !g[i-1]);
        chk($sformatf("tie%0d_rdv1", i), m1_readdatavalid, g[i-1]);
        chk($sformatf("tie%0d_data", i), m0_readdata, g[i-1] ? 32'hFFFF3344 : 32'hDEADBEEF);
      end
      next_cycle();
    end
    m0_read = 0;
    #1 chk("solo1_wait1", m1_waitrequest, 0);
    chk("solo1_rdv0", m0_readdatavalid, !g[3]);
    chk("solo1_rdv1", m1_readdatavalid, g[3]);
    next_cycle(); idle();
    #1 chk("solo1_ret", m1_readdatavalid, 1);
    chk("solo1_data", m1_readdata, 32'hFFFF3344);

    // Reset in the cycle after a read acceptance
    next_cycle(); drive0(1, 0, 16'h0010, 4'hF, 32'h0);
    #1 chk("pre_rst_wait0", m0_waitrequest, 0);
    next_cycle(); idle(); reset_n = 0;
    #1 chk("rst2_rdv0", m0_readdatavalid, 0);
    chk("rst2_clken", mem_clken, 0);
    next_cycle(); reset_n = 1;
    #1 chk("rel_rdv0", m0_readdatavalid, 0);
    next_cycle();
    drive0(1, 0, 16'h0010, 4'hF, 32'h0);
    drive1(1, 0, 16'h0020, 4'hF, 32'h0);
    #1 chk("rel_tie_wait0", m0_waitrequest, 0);
    chk("rel_tie_wait1", m1_waitrequest, 1);
    next_cycle(); idle();
    #1 chk("rel_rdv0_ret", m0_readdatavalid, 1);
    chk("rel_data", m0_readdata, 32'hDEADBEEF);

    // Read and write together execute as a write only
    next_cycle(); drive0(1, 1, 16'h0030, 4'hF, 32'hCAFEF00D);
    #1 chk("rw_wait0", m0_waitrequest, 0);
    chk("rw_memwr", mem_write, 1);
    next_cycle(); idle();
    #1 chk("rw_no_rdv0", m0_readdatavalid, 0);
    chk("rw_no_rdv1", m1_readdatavalid, 0);
    next_cycle(); drive0(1, 0, 16'h0030, 4'hF, 32'h0);
    next_cycle(); idle();
    #1 chk("rw_rdv0", m0_readdatavalid, 1);
    chk("rw_data", m0_readdata, 32'hCAFEF00D);

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word address width of the shared memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width BE_W = DATA_W/8.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL provide, for each requester N in {0,1}, the following ports:
- mN_address, input, ADDR_W, word address.
- mN_byteenable, input, BE_W, write byte lanes.
- mN_read, input, 1, read request.
- mN_write, input, 1, write request.
- mN_writedata, input, DATA_W, write data.
- mN_waitrequest, output, 1, request not accepted this cycle.
- mN_readdata, output, DATA_W, read data.
- mN_readdatavalid, output, 1, mN_readdata valid.
REQ-007 SHALL have the following memory-side ports:
- mem_address, output, ADDR_W, to RAM.
- mem_byteenable, output, BE_W.
- mem_chipselect, output, 1.
- mem_write, output, 1.
- mem_writedata, output, DATA_W.
- mem_clken, output, 1.
- mem_readdata, input, DATA_W, RAM q, valid one cycle after the address edge.

Function
REQ-008 SHALL treat requester N as requesting when mN_read|mN_write; mN_read&mN_write together SHALL be executed as a write only, with no readdatavalid.
REQ-009 SHALL grant at most one requester per cycle, combinationally from current requests and registered last_grant; the granted requester sees waitrequest=0, the other requesting one sees waitrequest=1; a non-requesting requester sees waitrequest=0.
REQ-010 SHALL drive mem_* from the granted requester in the same cycle, with mem_chipselect=1 and mem_write = granted write; with no grant, mem_chipselect=0, mem_write=0, and mem_address/mem_byteenable/mem_writedata held at their last driven values.
REQ-011 SHALL update last_grant to the granted index on every accepted transfer and hold it otherwise.
REQ-012 SHALL issue reads with fixed latency 1: a read accepted in cycle T SHALL assert mN_readdatavalid in cycle T+1 only for the owner, with mN_readdata = mem_readdata.
REQ-013 SHALL track the owner in registers rd_pend (1 bit) and rd_owner (1 bit); both SHALL be loaded each cycle.
REQ-014 SHALL sustain one accepted transfer per cycle, with back-to-back reads from alternating requesters each returning at T+1.
REQ-015 SHALL drive the non-owner mN_readdata with the same mem_readdata value and readdatavalid=0.
REQ-016 SHALL drive mem_clken = reset_n.
REQ-017 SHALL give a write accepted in T followed by a read of the same address in T+1 the new data at T+2, as native RAM behaviour, with no hazard logic.

Reset
REQ-018 While reset_n=0 at a clock edge, the block SHALL set last_grant=1 (so requester 0 wins the first tie), rd_pend=0, rd_owner=0, and hold both mN_readdatavalid=0.
REQ-019 While reset_n=0, the block SHALL force mem_chipselect=0, mem_write=0, mem_clken=0, and both mN_waitrequest=1.
REQ-020 Reset asserted in the cycle after a read acceptance SHALL suppress that read's readdatavalid.

Configuration
REQ-021 With ONCHIP_ARB_ROUND_ROBIN_EN defined, the block SHALL resolve a tie by granting the requester other than last_grant.
REQ-022 Without ONCHIP_ARB_ROUND_ROBIN_EN, the block SHALL always grant requester 0 on a tie, and last_grant SHALL be kept but SHALL not affect arbitration.

Verification
REQ-023 Reset, then m0 writes 0xDEADBEEF to 0x0010 with be=0xF, then m0 reads 0x0010 -> m0_waitrequest=0 both cycles; m0_readdatavalid=1 exactly one cycle after the read with data 0xDEADBEEF.
REQ-024 m0 and m1 read continuously for 4 cycles (round-robin on) -> grants 0,1,0,1; readdatavalid alternates 0,1,0,1 one cycle later; the loser's waitrequest=1.
REQ-025 Same stimulus as REQ-024 with the macro undefined -> m0 is granted all 4 cycles; m1_waitrequest=1 throughout; m1 is granted in the cycle m0 drops.
REQ-026 m1 writes 0x11223344 to 0x0020 with be=0x3 over prior 0xFFFFFFFF, then reads it -> 0xFFFF3344.
REQ-027 m0 read accepted, then reset_n=0 on the next edge -> m0_readdatavalid stays 0, mem_clken=0, and the first tie after release is granted to m0.
REQ-028 m0 asserts read and write together to 0x0030 -> memory written; no m0_readdatavalid follows.
